piso_serializer_ctrl: RTL
=========================

PISO_SERIALIZER_CTRL -- requirements
Module: piso_serializer_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter WIDTH, default 4, is the parallel word width; legal range is 2..32.
REQ-003 Parameter LSB_FIRST, default 1: when 1, bit 0 is sent first; when 0, bit WIDTH-1 is sent first.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream has a word on in_data.
REQ-007 in_data  input  WIDTH  parallel word to serialize.
REQ-008 in_ready  output  1  block accepts in_data on this edge.
REQ-009 ser_ready  input  1  downstream accepts ser_out on this edge.
REQ-010 ser_out  output  1  current serial bit.
REQ-011 ser_valid  output  1  ser_out holds a valid bit.
REQ-012 ser_first  output  1  current bit is the first bit of a word.
REQ-013 ser_last  output  1  current bit is the last bit of a word.
REQ-014 busy  output  1  a word is being shifted out.

Function
REQ-015 A word is accepted on a rising edge where in_valid=1 and in_ready=1; a bit is consumed on a rising edge where ser_valid=1 and ser_ready=1.
REQ-016 The FSM SHALL have two states: IDLE and SHIFT.
REQ-017 In IDLE, in_ready=1, ser_valid=0, ser_out=0, ser_first=0, ser_last=0 and busy=0.
REQ-018 IDLE->SHIFT on word acceptance: the word is loaded into the shift register and the bit counter is cleared.
REQ-019 Latency: the first bit SHALL appear on ser_out, with ser_valid=1 and ser_first=1, in the cycle after acceptance.
REQ-020 In SHIFT: ser_valid=1 and busy=1; ser_first=1 iff count==0; ser_last=1 iff count==WIDTH-1.
REQ-021 Each consumed bit shifts the register by one position toward the output end, zero-filled, and increments the count.
REQ-022 If ser_ready=0, the register, count, ser_out, ser_first and ser_last SHALL hold; ser_valid SHALL stay 1.
REQ-023 In SHIFT, in_ready = ser_last AND ser_ready (combinational path from ser_ready); otherwise in_ready=0.
REQ-024 When the last bit is consumed and in_valid=1: load the next word and stay in SHIFT with count=0, so serial output has no gap.
REQ-025 When the last bit is consumed and in_valid=0: go to IDLE.
REQ-026 in_valid or in_data changes while in_ready=0 SHALL have no effect.
REQ-027 The count width is clog2(WIDTH); the count never exceeds WIDTH-1.

Reset
REQ-028 Asserting reset SHALL immediately force: state IDLE, shift register 0, count 0, ser_out/ser_valid/ser_first/ser_last/busy all 0.
REQ-029 in_ready SHALL be 0 while reset is asserted; it returns to 1 in the first cycle after deassertion.
REQ-030 Reset mid-word discards the partial word; no residual bits SHALL appear after release.

Structure
REQ-031 Package piso_pkg SHALL hold the FSM state typedef (IDLE, SHIFT) and the default constants for WIDTH and LSB_FIRST.
REQ-032 The datapath SHALL be one sub-module, piso_shreg, holding the parameterized shift register: async reset, load and shift-enable inputs, direction set by LSB_FIRST.
REQ-033 The FSM, counter and handshake logic SHALL live in piso_serializer_ctrl.

Verification (WIDTH=4 unless stated)
REQ-034 Reset: hold reset=1 for 3 cycles with in_valid=1 -> all outputs 0 throughout, no word accepted.
REQ-035 Single word: in_data=4'b1011, LSB_FIRST=1, ser_ready=1 -> ser_out 1,1,0,1 on cycles 1-4; ser_first on cycle 1, ser_last on cycle 4; busy=0 on cycle 5.
REQ-036 Backpressure: same word, ser_ready=0 for 2 cycles during bit 1 -> ser_out holds 1 with ser_valid=1; total duration 6 cycles; bit order unchanged.
REQ-037 Back-to-back: 4'b1011 then 4'b0110 with in_valid held high -> 8 contiguous valid bits 1,1,0,1,0,1,1,0; in_ready=1 only during the two ser_last cycles.
REQ-038 Reset mid-word: assert reset after 2 bits of 4'b1011 -> outputs go to 0 at once; after release, ser_valid stays 0 until a new word is accepted.
REQ-039 MSB first: LSB_FIRST=0, in_data=4'b1011 -> ser_out 1,0,1,1.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and default parameters for the parallel-in serial-out serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int PISO_WIDTH     = 4;
  localparam bit PISO_LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_shreg.sv
// Parameterized shift register: parallel load, one-position zero-filled shift
// toward the output end, output bit selected by LSB_FIRST.
module piso_shreg
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_WIDTH,
  parameter bit LSB_FIRST = PISO_LSB_FIRST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] data_q;

  // Load wins over shift so a back-to-back word replaces the drained one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end else if (shift_i) begin
      data_q <= LSB_FIRST ? (data_q >> 1) : (data_q << 1);
    end
  end

  assign bit_o = LSB_FIRST ? data_q[0] : data_q[WIDTH-1];

endmodule

// File: rtl/piso_serializer_ctrl.sv
// Serializer top: IDLE/SHIFT handshake FSM and bit counter around piso_shreg.
// A word is taken on the last-bit edge so consecutive words stream without a gap.
module piso_serializer_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_WIDTH,
  parameter bit LSB_FIRST = PISO_LSB_FIRST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          load, shift_en, accept, atLast, shregBit;

  assign atLast = (state_q == SHIFT) && (count_q == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // in_ready is held low during reset so nothing is accepted while the block is cleared.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    accept    = 1'b0;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_first = 1'b0;
    ser_last  = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = ~reset;
        accept   = in_valid && ~reset;
        if (accept) begin
          load    = 1'b1;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        ser_first = (count_q == '0);
        ser_last  = atLast;
        in_ready  = atLast && ser_ready;
        accept    = in_valid && atLast && ser_ready;
        if (ser_ready) begin
          if (atLast) begin
            count_d = '0;
            if (accept) begin
              load = 1'b1;
            end else begin
              shift_en = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            count_d  = count_q + 1'b1;
            shift_en = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  piso_shreg #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_shreg (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .shift_i(shift_en),
    .data_i (in_data),
    .bit_o  (shregBit)
  );

  assign ser_out = (state_q == SHIFT) ? shregBit : 1'b0;

endmodule
